// File: rtl/elevator_disp_pkg.sv
// Shared codes, segment patterns and converter state type for the elevator
// floor/direction display.
package elevator_disp_pkg;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  localparam int BCD_NIBBLES = 4;
  localparam int BCD_W       = 4 * BCD_NIBBLES;

  // Active-low patterns, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_UP    = 7'b1011100;
  localparam logic [6:0] SEG_DOWN  = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_LOAD  = 2'b10
  } conv_state_t;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

  function automatic logic [6:0] seg_dir(input logic [1:0] dir);
    case (dir)
      DIR_UP:   return SEG_UP;
      DIR_DOWN: return SEG_DOWN;
      DIR_IDLE: return SEG_DASH;
      default:  return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/elevator_display_ctrl_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift-and-adjust step
// per clock, FLOOR_W steps per conversion, result held while in LOAD.
module bin2bcd_seq
  import elevator_disp_pkg::*;
#(
  parameter int FLOOR_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [FLOOR_W-1:0] din,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);

  localparam logic [3:0] CNT_LAST = 4'(FLOOR_W - 1);

  conv_state_t        state_r;
  logic [FLOOR_W-1:0] bin_r;
  logic [BCD_W-1:0]   bcd_r;
  logic [BCD_W-1:0]   adj_s;
  logic [3:0]         cnt_r;

  // Add 3 to every nibble that would overflow past 9 on the next shift.
  always_comb begin
    adj_s = bcd_r;
    for (int i = 0; i < BCD_NIBBLES; i++) begin
      if (bcd_r[i*4 +: 4] >= 4'd5) begin
        adj_s[i*4 +: 4] = bcd_r[i*4 +: 4] + 4'd3;
      end else begin
        adj_s[i*4 +: 4] = bcd_r[i*4 +: 4];
      end
    end
  end

  // Conversion FSM and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      bin_r   <= '0;
      bcd_r   <= '0;
      cnt_r   <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            bin_r   <= din;
            bcd_r   <= '0;
            cnt_r   <= 4'd0;
            state_r <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {bcd_r, bin_r} <= {adj_s[BCD_W-2:0], bin_r, 1'b0};
          cnt_r          <= cnt_r + 4'd1;
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_r != ST_IDLE);
  assign done = (state_r == ST_LOAD);
  assign bcd  = bcd_r;

endmodule

// File: rtl/elevator_display_ctrl.sv
// Multiplexed elevator display: decimal floor digits plus a direction glyph,
// scanned one position at a time, and a door/alarm LED.
module elevator_display_ctrl
  import elevator_disp_pkg::*;
#(
  parameter int FLOOR_W   = 6,
  parameter int DIGITS    = 2,
  parameter int SCAN_DIV  = 16,
  parameter int BLINK_DIV = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOOR_W-1:0] current_floor,
  input  logic [1:0]         direction,
  input  logic               open,
  input  logic               alarm,
  output logic [6:0]         seg,
  output logic [DIGITS:0]    an,
  output logic               led,
  output logic               busy
);

  localparam int PW      = $clog2(DIGITS + 1);
  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [PW-1:0]      POS_LAST   = PW'(DIGITS);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [FLOOR_W-1:0]  last_r;
  logic                start_s;
  logic                conv_busy_s;
  logic                conv_done_s;
  logic [BCD_W-1:0]    bcd_s;
  logic [DIGITS*4-1:0] digits_r;
  logic                over_r;
  logic [PRESC_W-1:0]  presc_r;
  logic [PW-1:0]       pos_r;
  logic [PW-1:0]       pos_next_s;
  logic [DIGITS-1:0]   blank_s;
  logic                lead_nz_s;
  logic [6:0]          slot_seg_s [DIGITS+1];
  logic [6:0]          seg_r;
  logic [DIGITS:0]     an_r;
  logic                led_r;
  logic                alarm_q_r;
  logic [BLINK_W-1:0]  blink_cnt_r;

  assign start_s = ~conv_busy_s & (current_floor != last_r);

  bin2bcd_seq #(.FLOOR_W(FLOOR_W)) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start_s),
    .din   (current_floor),
    .busy  (conv_busy_s),
    .done  (conv_done_s),
    .bcd   (bcd_s)
  );

  // Remember the value being converted and latch finished results.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_r   <= '0;
      digits_r <= '0;
      over_r   <= 1'b0;
    end else begin
      if (start_s) begin
        last_r <= current_floor;
      end
      if (conv_done_s) begin
        digits_r <= bcd_s[DIGITS*4-1:0];
        over_r   <= |bcd_s[BCD_W-1:DIGITS*4];
      end
    end
  end

  // Next scan position, leading-zero blanking and per-position glyphs.
  always_comb begin
    if (presc_r == PRESC_LAST) begin
      if (pos_r == POS_LAST) begin
        pos_next_s = '0;
      end else begin
        pos_next_s = pos_r + PW'(1);
      end
    end else begin
      pos_next_s = pos_r;
    end
    lead_nz_s = 1'b0;
    blank_s   = '0;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      lead_nz_s  = lead_nz_s | (digits_r[d*4 +: 4] != 4'd0);
      blank_s[d] = ~lead_nz_s;
    end
    slot_seg_s[0] = seg_dir(direction);
    for (int d = 0; d < DIGITS; d++) begin
      if (over_r) begin
        slot_seg_s[d+1] = SEG_DASH;
      end else if (blank_s[d]) begin
        slot_seg_s[d+1] = SEG_BLANK;
      end else begin
        slot_seg_s[d+1] = seg_digit(digits_r[d*4 +: 4]);
      end
    end
  end

  // Scan prescaler and registered anode/segment drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= '0;
      pos_r   <= '0;
      an_r    <= {{DIGITS{1'b1}}, 1'b0};
      seg_r   <= SEG_DASH;
    end else begin
      presc_r <= (presc_r == PRESC_LAST) ? '0 : presc_r + PRESC_W'(1);
      pos_r   <= pos_next_s;
      an_r    <= ~({{DIGITS{1'b0}}, 1'b1} << pos_next_s);
      seg_r   <= slot_seg_s[pos_next_s];
    end
  end

  // Door LED, overridden by a blink that restarts high on each alarm rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_r       <= 1'b0;
      alarm_q_r   <= 1'b0;
      blink_cnt_r <= '0;
    end else begin
      alarm_q_r <= alarm;
      if (!alarm) begin
        led_r       <= open;
        blink_cnt_r <= '0;
      end else if (!alarm_q_r) begin
        led_r       <= 1'b1;
        blink_cnt_r <= '0;
      end else if (blink_cnt_r == BLINK_LAST) begin
        led_r       <= ~led_r;
        blink_cnt_r <= '0;
      end else begin
        blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
      end
    end
  end

  assign seg  = seg_r;
  assign an   = an_r;
  assign led  = led_r;
  assign busy = conv_busy_s;

endmodule

// File: tb/tb_elevator_display_ctrl.sv
// Directed self-checking bench for elevator_display_ctrl (DIGITS=2 main
// instance plus a DIGITS=1 instance on the same inputs).
module tb_elevator_display_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] current_floor;
  logic [1:0] direction;
  logic       open;
  logic       alarm;
  logic [6:0] seg, seg1;
  logic [2:0] an;
  logic [1:0] an1;
  logic       led, led1, busy, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  elevator_display_ctrl dut (
    .clk(clk), .reset(reset), .current_floor(current_floor),
    .direction(direction), .open(open), .alarm(alarm),
    .seg(seg), .an(an), .led(led), .busy(busy)
  );

  elevator_display_ctrl #(.DIGITS(1)) dut1 (
    .clk(clk), .reset(reset), .current_floor(current_floor),
    .direction(direction), .open(open), .alarm(alarm),
    .seg(seg1), .an(an1), .led(led1), .busy(busy1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_slot(input logic [2:0] target, output logic [6:0] s);
    logic found;
    found = 1'b0;
    s = 7'h00;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (an === target) begin
        found = 1'b1;
        s = seg;
      end
    end
    check_eq("slot_reached", 32'(found), 32'd1);
  endtask

  task automatic wait_slot1(output logic [6:0] s);
    logic found;
    found = 1'b0;
    s = 7'h00;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (an1 === 2'b01) begin
        found = 1'b1;
        s = seg1;
      end
    end
    check_eq("slot1_reached", 32'(found), 32'd1);
  endtask

  // Leaves the bench at the first negedge of the ones-digit slot.
  task automatic sync_slot1();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (an === 3'b110) found = 1'b1;
    end
    check_eq("sync_dir_slot", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 32 && !found; i++) begin
      @(negedge clk);
      if (an === 3'b101) found = 1'b1;
    end
    check_eq("sync_ones_slot", 32'(found), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] s;
    logic [1:0] dir_vec [4];
    logic [6:0] dir_exp [4];
    dir_vec = '{2'b01, 2'b10, 2'b00, 2'b11};
    dir_exp = '{7'b1011100, 7'b1100011, 7'b0111111, 7'b0111111};

    reset = 1'b1; current_floor = 6'd0; direction = 2'b00; open = 1'b0; alarm = 1'b0;
    tick(3);
    check_eq("rst_an", 32'(an), 32'(3'b110));
    check_eq("rst_seg", 32'(seg), 32'(7'b0111111));
    check_eq("rst_led", 32'(led), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Anode rotation every 16 cycles with floor 0 on the digits.
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      if (i == 15) begin
        check_eq("rot_hold", 32'(an), 32'(3'b110));
      end else if (i == 16) begin
        check_eq("rot_an1", 32'(an), 32'(3'b101));
        check_eq("zero_ones", 32'(seg), 32'(7'b1000000));
      end else if (i == 32) begin
        check_eq("rot_an2", 32'(an), 32'(3'b011));
        check_eq("zero_tens_blank", 32'(seg), 32'(7'b1111111));
      end else if (i == 48) begin
        check_eq("rot_wrap", 32'(an), 32'(3'b110));
        check_eq("dir_idle_seg", 32'(seg), 32'(7'b0111111));
      end
    end

    // Floor 5: exact conversion latency seen inside the ones slot.
    sync_slot1();
    tick(3);
    current_floor = 6'd5;
    tick(1);
    check_eq("f5_busy_start", 32'(busy), 32'd1);
    tick(6);
    check_eq("f5_busy_last", 32'(busy), 32'd1);
    tick(1);
    check_eq("f5_busy_done", 32'(busy), 32'd0);
    check_eq("f5_not_yet", 32'(seg), 32'(7'b1000000));
    tick(1);
    check_eq("f5_ones", 32'(seg), 32'(7'b0010010));
    wait_slot(3'b011, s);
    check_eq("f5_tens_blank", 32'(s), 32'(7'b1111111));

    // Floor 12, changed to 3 mid-shift: 12 shown first, then 3.
    sync_slot1();
    tick(3);
    current_floor = 6'd12;
    tick(1);
    check_eq("f12_busy", 32'(busy), 32'd1);
    tick(3);
    current_floor = 6'd3;
    tick(7);
    check_eq("f12_ones", 32'(seg), 32'(7'b0100100));
    check_eq("f12_restart_busy", 32'(busy), 32'd1);
    tick(3);
    check_eq("f12_tens_an", 32'(an), 32'(3'b011));
    check_eq("f12_tens", 32'(seg), 32'(7'b1111001));
    tick(20);
    wait_slot(3'b101, s);
    check_eq("f3_ones", 32'(s), 32'(7'b0110000));
    wait_slot(3'b011, s);
    check_eq("f3_tens_blank", 32'(s), 32'(7'b1111111));

    // Floor 63: two digits fit, one digit overflows to a dash.
    current_floor = 6'd63;
    tick(12);
    wait_slot(3'b101, s);
    check_eq("f63_ones", 32'(s), 32'(7'b0110000));
    wait_slot(3'b011, s);
    check_eq("f63_tens", 32'(s), 32'(7'b0000010));
    wait_slot1(s);
    check_eq("f63_d1_dash", 32'(s), 32'(7'b0111111));

    // Direction glyphs.
    for (int k = 0; k < 4; k++) begin
      direction = dir_vec[k];
      wait_slot(3'b110, s);
      check_eq($sformatf("dir_%0d", k), 32'(s), 32'(dir_exp[k]));
    end

    // LED follows open, then blinks under alarm.
    open = 1'b1;
    tick(1);
    check_eq("led_open", 32'(led), 32'd1);
    alarm = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (i == 64) check_eq("blink_high_end", 32'(led), 32'd1);
      else if (i == 65) check_eq("blink_toggle_low", 32'(led), 32'd0);
    end
    alarm = 1'b0;
    tick(1);
    check_eq("led_release", 32'(led), 32'd1);
    open = 1'b0;
    alarm = 1'b1;
    for (int i = 1; i <= 65; i++) begin
      @(negedge clk);
      if (i == 1) check_eq("blink_start_high", 32'(led), 32'd1);
      else if (i == 64) check_eq("blink2_high_end", 32'(led), 32'd1);
      else if (i == 65) check_eq("blink2_low", 32'(led), 32'd0);
    end
    alarm = 1'b0;
    tick(1);
    check_eq("led_closed", 32'(led), 32'd0);

    // Reset three cycles into a conversion of floor 9.
    current_floor = 6'd9;
    tick(1);
    check_eq("f9_busy", 32'(busy), 32'd1);
    tick(3);
    reset = 1'b1;
    tick(1);
    check_eq("mid_rst_an", 32'(an), 32'(3'b110));
    check_eq("mid_rst_seg", 32'(seg), 32'(7'b0111111));
    check_eq("mid_rst_led", 32'(led), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_an_d1", 32'(an1), 32'(2'b10));
    check_eq("mid_rst_busy_d1", 32'(busy1), 32'd0);
    reset = 1'b0;
    tick(1);
    check_eq("f9_restart", 32'(busy), 32'd1);
    tick(7);
    check_eq("f9_done", 32'(busy), 32'd0);
    wait_slot(3'b101, s);
    check_eq("f9_ones", 32'(s), 32'(7'b0010000));
    wait_slot(3'b011, s);
    check_eq("f9_tens_blank", 32'(s), 32'(7'b1111111));
    wait_slot1(s);
    check_eq("f9_d1_ones", 32'(s), 32'(7'b0010000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
